// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: two-port round-robin request arbiter in front of a shared bus, with an
// outstanding-read tag table that steers multi-beat responses back to the issuing port.
module sysbus_arbiter #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned TAG_WIDTH   = 13,
  parameter int unsigned RESP_BEATS  = 8,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester port 0
  input  logic                  p0_reqcyc,
  input  logic [DATA_WIDTH-1:0] p0_req,
  input  logic [TAG_WIDTH-1:0]  p0_reqtag,
  input  logic                  p0_reqrd,
  input  logic                  p0_reqlast,
  output logic                  p0_reqack,
  output logic                  p0_respcyc,
  output logic [DATA_WIDTH-1:0] p0_resp,
  output logic [TAG_WIDTH-1:0]  p0_resptag,
  input  logic                  p0_respack,
  // requester port 1
  input  logic                  p1_reqcyc,
  input  logic [DATA_WIDTH-1:0] p1_req,
  input  logic [TAG_WIDTH-1:0]  p1_reqtag,
  input  logic                  p1_reqrd,
  input  logic                  p1_reqlast,
  output logic                  p1_reqack,
  output logic                  p1_respcyc,
  output logic [DATA_WIDTH-1:0] p1_resp,
  output logic [TAG_WIDTH-1:0]  p1_resptag,
  input  logic                  p1_respack,
  // shared bus
  output logic [DATA_WIDTH-1:0] req,
  output logic [TAG_WIDTH-1:0]  reqtag,
  output logic                  reqcyc,
  input  logic                  reqack,
  input  logic [DATA_WIDTH-1:0] resp,
  input  logic [TAG_WIDTH-1:0]  resptag,
  input  logic                  respcyc,
  output logic                  respack,
  // status
  output logic                  err_unmatched
);

  localparam int unsigned IdxW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(RESP_BEATS + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  // Request FSM state
  logic [0:0] state_q, state_d;
  logic       grant_q, grant_d;   // port holding the grant
  logic       rr_q, rr_d;         // port favoured on the next tie
  logic       first_q, first_d;   // next transferred beat is the first of the burst

  // Outputs stay quiet during reset and the first cycle after release
  logic out_en_q;
  logic en;

  logic err_q, err_d;

  // Outstanding-read table
  logic [OUTSTANDING-1:0] valid_q, valid_d;
  logic [OUTSTANDING-1:0] port_q, port_d;
  logic [TAG_WIDTH-1:0]   tag_q [OUTSTANDING];
  logic [TAG_WIDTH-1:0]   tag_d [OUTSTANDING];
  logic [CntW-1:0]        cnt_q [OUTSTANDING];
  logic [CntW-1:0]        cnt_d [OUTSTANDING];

  // Request-side decode
  logic       busy;
  logic       g_cyc, g_rd, g_last;
  logic       req_xfer;
  logic [1:0] elig;
  logic       winner;
  logic       alloc_ok;
  logic [IdxW-1:0] alloc_idx;
  logic       alloc;

  // Response-side decode
  logic            hit;
  logic [IdxW-1:0] hit_idx;
  logic            hit_port;
  logic            port_respack;
  logic            resp_xfer;

  assign en = out_en_q & reset;

  // Bus request mirrors whichever port holds the grant
  assign busy   = (state_q == StBusy);
  assign g_cyc  = grant_q ? p1_reqcyc  : p0_reqcyc;
  assign g_rd   = grant_q ? p1_reqrd   : p0_reqrd;
  assign g_last = grant_q ? p1_reqlast : p0_reqlast;
  assign req    = grant_q ? p1_req     : p0_req;
  assign reqtag = grant_q ? p1_reqtag  : p0_reqtag;

  assign reqcyc    = en & busy & g_cyc;
  assign p0_reqack = en & busy & ~grant_q & reqack;
  assign p1_reqack = en & busy & grant_q & reqack;
  assign req_xfer  = reqcyc & reqack;

  // Table lookups: lowest free entry for allocation, lowest matching entry for responses
  always_comb begin
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    hit       = 1'b0;
    hit_idx   = '0;
    for (int i = int'(OUTSTANDING) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = IdxW'(i);
      end
      if (valid_q[i] && (tag_q[i] == resptag)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  // A read needs a free entry at grant time; writes are always eligible
  assign elig[0] = p0_reqcyc & (~p0_reqrd | alloc_ok);
  assign elig[1] = p1_reqcyc & (~p1_reqrd | alloc_ok);
  assign winner  = (elig[0] & elig[1]) ? rr_q : elig[1];

  assign alloc = req_xfer & first_q & g_rd & alloc_ok;

  // Response routing to the owning port; unmatched beats are swallowed
  assign hit_port     = port_q[hit_idx];
  assign port_respack = hit_port ? p1_respack : p0_respack;

  assign p0_resp    = resp;
  assign p1_resp    = resp;
  assign p0_resptag = resptag;
  assign p1_resptag = resptag;

  assign p0_respcyc = en & respcyc & hit & ~hit_port;
  assign p1_respcyc = en & respcyc & hit & hit_port;
  assign respack    = en & respcyc & (hit ? port_respack : 1'b1);
  assign resp_xfer  = respcyc & respack;

  assign err_unmatched = err_q;

  // Request FSM: grant from IDLE, release after the last transferred beat
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    first_d = first_q;
    case (state_q)
      StIdle: begin
        if (|elig) begin
          state_d = StBusy;
          grant_d = winner;
          rr_d    = ~winner;
          first_d = 1'b1;
        end
      end
      StBusy: begin
        if (req_xfer) begin
          first_d = 1'b0;
          if (g_last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Table update: response retire and request allocation touch distinct entries
  always_comb begin
    valid_d = valid_q;
    port_d  = port_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (resp_xfer) begin
      if (hit) begin
        cnt_d[hit_idx] = cnt_q[hit_idx] + 1'b1;
        if (cnt_q[hit_idx] == CntW'(RESP_BEATS - 1)) begin
          valid_d[hit_idx] = 1'b0;
        end
      end else begin
        err_d = 1'b1;
      end
    end
    if (alloc) begin
      valid_d[alloc_idx] = 1'b1;
      port_d[alloc_idx]  = grant_q;
      tag_d[alloc_idx]   = reqtag;
      cnt_d[alloc_idx]   = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      first_q  <= 1'b0;
      out_en_q <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= '0;
      port_q   <= '0;
      for (int i = 0; i < int'(OUTSTANDING); i++) begin
        tag_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      first_q  <= first_d;
      out_en_q <= 1'b1;
      err_q    <= err_d;
      valid_q  <= valid_d;
      port_q   <= port_d;
      tag_q    <= tag_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/sysbus_arbiter.md
SYSBUS_ARBITER -- requirements
Module: sysbus_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the width of request and response data.
REQ-002 Parameter TAG_WIDTH, default 13, SHALL set the width of request and response tags.
REQ-003 Parameter RESP_BEATS, default 8, SHALL set the number of response beats returned per read request.
REQ-004 Parameter OUTSTANDING, default 4, SHALL set the depth of the outstanding-read tag table.
REQ-005 Clock and reset ports SHALL be:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-low reset.
REQ-006 Requester ports SHALL be, for each port pN with N in {0,1}:
- pN_reqcyc  in  1  request beat valid.
- pN_req  in  DATA_WIDTH  request beat.
- pN_reqtag  in  TAG_WIDTH  request tag.
- pN_reqrd  in  1  burst expects a response; sampled on the first beat.
- pN_reqlast  in  1  final beat of the burst.
- pN_reqack  out  1  beat accepted.
- pN_respcyc  out  1  response beat valid.
- pN_resp  out  DATA_WIDTH  response data.
- pN_resptag  out  TAG_WIDTH  response tag.
- pN_respack  in  1  response beat consumed.
REQ-007 Bus ports SHALL be:
- req  out  DATA_WIDTH  request beat.
- reqtag  out  TAG_WIDTH  request tag.
- reqcyc  out  1  request beat valid.
- reqack  in  1  request beat accepted.
- resp  in  DATA_WIDTH  response data.
- resptag  in  TAG_WIDTH  response tag.
- respcyc  in  1  response beat valid.
- respack  out  1  response beat consumed.
REQ-008 Status output err_unmatched  out  1 SHALL be a sticky flag for a response whose tag has no table entry.

Function
REQ-009 The request FSM SHALL have two states:
- IDLE: no grant held.
- BUSY: grant held by exactly one port.
REQ-010 In IDLE, a port SHALL be eligible when pN_reqcyc=1 and either pN_reqrd=0 or the tag table has a free entry.
REQ-011 When in IDLE with at least one eligible port, the FSM SHALL register a grant, enter BUSY on the next edge, and update the round-robin pointer.
REQ-012 Arbitration SHALL be round-robin: on a tie, the port not granted most recently wins; port 0 wins the first tie after reset.
REQ-013 In BUSY, the bus-side request outputs SHALL behave as follows:
- reqcyc SHALL equal the granted pN_reqcyc.
- req and reqtag SHALL mirror the granted port combinationally.
- The non-granted pN_reqack SHALL be 0.
REQ-014 The granted pN_reqack SHALL equal reqack.
REQ-015 A beat SHALL transfer only in a cycle where reqcyc=1 and reqack=1.
REQ-016 A transferred beat with pN_reqlast=1 SHALL return the FSM to IDLE on the next edge, leaving at least one IDLE cycle between bursts.
REQ-017 A transferred first beat with pN_reqrd=1 SHALL allocate the lowest free table entry, storing the tag, the port and a beat count of 0.
REQ-018 The response side SHALL work as follows:
- On respcyc=1, resptag SHALL be matched against valid entries, and the lowest-index match wins.
- The matched port SHALL see pN_respcyc=1 with pN_resp=resp and pN_resptag=resptag.
- respack SHALL equal that port's pN_respack, combinationally.
- Each response beat transfers in a cycle where respcyc=1 and respack=1.
REQ-019 Each transferred response beat SHALL increment the entry's beat count; the beat making the count RESP_BEATS SHALL invalidate the entry on that edge.
REQ-020 When no entry matches, respack SHALL be 1, the beat SHALL be dropped, and err_unmatched SHALL set.
REQ-021 Allocation and deallocation in the same cycle SHALL both take effect, and an entry freed this edge SHALL be allocatable from the next cycle.
REQ-022 Request and response paths SHALL operate independently and concurrently.
REQ-023 Tag uniqueness among outstanding reads SHALL be the requesters' responsibility; duplicates resolve per REQ-018.

Reset
REQ-024 When reset=0 at a rising edge, the block SHALL clear all state:
- FSM to IDLE.
- Round-robin pointer to favour port 0.
- All table entries invalid.
- err_unmatched=0.
REQ-025 While in reset and during the first cycle after release, the block SHALL drive reqcyc=0, pN_reqack=0, pN_respcyc=0 and respack=0.
REQ-026 A reset during BUSY or during a response SHALL abandon the transfer without completing it.

Verification
REQ-027 The bench SHALL cover:
- Round-robin: p0 and p1 both present single-beat reads (tag 0x10 / 0x20) from reset, reqack held 1 → bus sees tag 0x10, one IDLE cycle, then 0x20.
- Write burst: p1 sends a 4-beat write (reqrd=0), reqack toggling 1,0,1,1,1 → exactly 4 beats transferred, grant released after the last, no table entry used.
- Table full: four p0 reads in flight, then a fifth read on p0 plus a write on p1 → write granted, p0 stalls until the 8th response beat of any entry, then is granted.
- Response routing: reads tag 0x05 (p0) and 0x06 (p1) in flight, responses interleaved, p1_respack held 0 for 3 cycles → respack=0 for those cycles, beats delivered only to the owner, both entries free after 8 beats each.
- Unmatched response: resptag 0x1FFF with an empty table → respack=1, both pN_respcyc=0, err_unmatched=1 until reset.
- Mid-burst reset: reset=0 on beat 2 of a 4-beat write → reqcyc=0 the next cycle, table empty, FSM IDLE, and after release port 0 wins the first tie.
